// File: rtl/fetch_ras_pkg.sv
// fetch_ras_pkg: shared types and defaults for the fetch stage.
// The return-address stack is built only when FETCH_RAS_EN is defined.
package fetch_ras_pkg;

  // Fetch-stage operating mode: program loading or instruction execution
  typedef enum logic {
    LOAD = 1'b0,
    EXEC = 1'b1
  } mode_t;

  localparam int DEF_INST_W    = 32;
  localparam int DEF_ADDR_W    = 12;
  localparam int DEF_RAS_DEPTH = 8;

  // Occupancy counter for the default stack depth (0..DEPTH inclusive)
  typedef logic [$clog2(DEF_RAS_DEPTH):0] ras_cnt_t;

endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack for fetch_ras.
// Push and pop are mutually exclusive (the caller gives pop priority).
// Overflow overwrites the oldest entry; popping while empty keeps the
// count at zero, still moves the pointer, and sets the sticky underflow.
module return_addr_stack #(
  parameter int ADDR_W    = 12,
  parameter int RAS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ADDR_W-1:0]            push_addr,
  output logic [ADDR_W-1:0]            top,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] FULL = RAS_DEPTH[PTR_W:0];

  logic [ADDR_W-1:0] stack [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  top_idx;

  // ptr names the next free slot, so the top lives one below it
  assign top_idx = ptr - 1'b1;
  assign top     = stack[top_idx];

  // Entry storage: not reset, written on push only
  always_ff @(posedge clk) begin
    if (push) begin
      stack[ptr] <= push_addr;
    end
  end

  // Pointer, saturating occupancy and sticky underflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      if (count != FULL) begin
        count <= count + 1'b1;
      end
    end else if (pop) begin
      ptr <= ptr - 1'b1;
      if (count != '0) begin
        count <= count - 1'b1;
      end else begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_ras.sv
// fetch_ras: instruction fetch stage with distributed-RAM instruction
// memory, PC register, registered instruction output and an optional
// return-address stack (enabled by defining FETCH_RAS_EN).
//
// Program-load handshake: in LOAD mode `we` is the valid strobe for
// `inst_in`; the stage is always ready in LOAD mode, so every cycle with
// we=1 transfers exactly one word to mem[pc] and advances pc.
module fetch_ras
  import fetch_ras_pkg::*;
#(
  parameter int INST_W    = DEF_INST_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  mode_t                        mode,
  input  logic                         we,
  input  logic [INST_W-1:0]            inst_in,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [ADDR_W-1:0]            flush_addr,
  input  logic                         prediction,
  input  logic                         dec_is_j,
  input  logic                         dec_is_b,
  input  logic                         dec_is_call,
  input  logic                         dec_is_jr,
  input  logic [ADDR_W-1:0]            dec_target,
  input  logic [ADDR_W-1:0]            ext_return_addr,
  output logic [ADDR_W-1:0]            pc,
  output logic [INST_W-1:0]            inst_out,
  output logic [ADDR_W-1:0]            inst_pc,
  output logic                         inst_valid,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_underflow
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [INST_W-1:0] mem [DEPTH];
  logic [INST_W-1:0] rd_data;
  logic [ADDR_W-1:0] fa;
  logic [ADDR_W-1:0] jr_target;
  mode_t             mode_q;
  logic              enter_exec;
  logic              mem_we;

  // First EXEC cycle after LOAD (or after reset) only rewinds pc
  assign enter_exec = (mode == EXEC) && (mode_q == LOAD);
  assign mem_we     = !reset && !flush && (mode == LOAD) && we;

`ifdef FETCH_RAS_EN
  logic              ras_en;
  logic              ras_push;
  logic              ras_pop;
  logic [ADDR_W-1:0] ras_push_addr;
  logic              unused_ext;

  // Stack updates only on real, non-stalled fetches of a valid instruction
  assign ras_en        = !flush && (mode == EXEC) && !enter_exec && !stall && inst_valid;
  assign ras_pop       = ras_en && dec_is_jr;
  // jr wins over a malformed call+jr, so no push in that case
  assign ras_push      = ras_en && dec_is_call && !dec_is_jr;
  assign ras_push_addr = inst_pc + 1'b1;
  assign unused_ext    = ^ext_return_addr;

  return_addr_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_addr (ras_push_addr),
    .top       (jr_target),
    .count     (ras_count),
    .underflow (ras_underflow)
  );
`else
  assign jr_target     = ext_return_addr;
  assign ras_count     = '0;
  assign ras_underflow = 1'b0;
`endif

  // Fetch address select; predecode flags are ignored when inst_out is not valid.
  // jr is tested before j so a malformed call+jr resolves to the return.
  always_comb begin
    fa = pc;
    if (flush) begin
      fa = flush_addr;
    end else if (inst_valid && dec_is_jr) begin
      fa = jr_target;
    end else if (inst_valid && (dec_is_j || (dec_is_b && prediction))) begin
      fa = dec_target;
    end
  end

  assign rd_data = mem[fa];

  // Instruction memory write port (LOAD mode only, never reset)
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[pc] <= inst_in;
    end
  end

  // PC, output instruction and mode tracking, in control-priority order
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= '0;
      inst_out   <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      mode_q     <= LOAD;
    end else begin
      mode_q <= mode;
      if (flush) begin
        inst_out   <= rd_data;
        inst_pc    <= fa;
        pc         <= fa + 1'b1;
        inst_valid <= 1'b1;
      end else if (mode == LOAD) begin
        inst_valid <= 1'b0;
        if (we) begin
          pc <= pc + 1'b1;
        end
      end else if (enter_exec) begin
        pc         <= '0;
        inst_valid <= 1'b0;
      end else if (!stall) begin
        inst_out   <= rd_data;
        inst_pc    <= fa;
        pc         <= fa + 1'b1;
        inst_valid <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // A valid instruction cannot be both a call and a return
  call_jr_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(inst_valid && dec_is_call && dec_is_jr));
`endif

endmodule

// File: tb/tb_fetch_ras.sv
// tb_fetch_ras: self-checking bench for fetch_ras.
// Acts as loader and decoder: the program encodes opcodes in inst[31:28],
// a taken-prediction bit in inst[27] and the target in inst[11:0].
// Expected fetches come from an ISA-level model with a LIFO return queue.
module tb_fetch_ras;
  import fetch_ras_pkg::*;

  localparam int INST_W    = 32;
  localparam int ADDR_W    = 12;
  localparam int RAS_DEPTH = 8;
  localparam int CNT_W     = $clog2(RAS_DEPTH) + 1;
  localparam int SB_W      = ADDR_W + INST_W;
  localparam int PROG_N    = 128;

  localparam logic [3:0] OP_J    = 4'd1;
  localparam logic [3:0] OP_B    = 4'd2;
  localparam logic [3:0] OP_CALL = 4'd3;
  localparam logic [3:0] OP_JR   = 4'd4;
  localparam logic [ADDR_W-1:0] EXT_RA = 12'h07F;

  // ---------------- clock / reset / DUT ----------------
  logic                clk;
  logic                reset;
  mode_t               mode;
  logic                we;
  logic [INST_W-1:0]   inst_in;
  logic                stall;
  logic                flush;
  logic [ADDR_W-1:0]   flush_addr;
  logic                prediction;
  logic                dec_is_j;
  logic                dec_is_b;
  logic                dec_is_call;
  logic                dec_is_jr;
  logic [ADDR_W-1:0]   dec_target;
  logic [ADDR_W-1:0]   ext_return_addr;
  logic [ADDR_W-1:0]   pc;
  logic [INST_W-1:0]   inst_out;
  logic [ADDR_W-1:0]   inst_pc;
  logic                inst_valid;
  logic [CNT_W-1:0]    ras_count;
  logic                ras_underflow;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_ras #(
    .INST_W    (INST_W),
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mode            (mode),
    .we              (we),
    .inst_in         (inst_in),
    .stall           (stall),
    .flush           (flush),
    .flush_addr      (flush_addr),
    .prediction      (prediction),
    .dec_is_j        (dec_is_j),
    .dec_is_b        (dec_is_b),
    .dec_is_call     (dec_is_call),
    .dec_is_jr       (dec_is_jr),
    .dec_target      (dec_target),
    .ext_return_addr (ext_return_addr),
    .pc              (pc),
    .inst_out        (inst_out),
    .inst_pc         (inst_pc),
    .inst_valid      (inst_valid),
    .ras_count       (ras_count),
    .ras_underflow   (ras_underflow)
  );

  // Combinational predecode of the instruction currently presented
  logic [3:0] dec_op;
  assign dec_op      = inst_out[31:28];
  assign dec_is_j    = (dec_op == OP_J) || (dec_op == OP_CALL);
  assign dec_is_b    = (dec_op == OP_B);
  assign dec_is_call = (dec_op == OP_CALL);
  assign dec_is_jr   = (dec_op == OP_JR);
  assign prediction  = inst_out[27];
  assign dec_target  = inst_out[ADDR_W-1:0];

  // ---------------- scoreboard / model state ----------------
  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  logic [SB_W-1:0]   exp_q[$];
  logic [ADDR_W-1:0] m_stack[$];
  logic [INST_W-1:0] prog [PROG_N];
  logic [ADDR_W-1:0] m_pc;
  logic [ADDR_W-1:0] m_cur;
  bit                m_valid;
  bit                m_unf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [INST_W-1:0] mk(input logic [3:0] op, input logic pred,
                                           input logic [ADDR_W-1:0] tgt);
    return {op, pred, 15'h0, tgt};
  endfunction

  function automatic logic [INST_W-1:0] word_at(input logic [ADDR_W-1:0] a);
    return prog[a[6:0]];
  endfunction

  function automatic logic [CNT_W-1:0] m_count();
`ifdef FETCH_RAS_EN
    return CNT_W'(m_stack.size());
`else
    return '0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Next fetch address the ISA would take, with return-queue side effects
  task automatic model_advance(output logic [ADDR_W-1:0] a, output bit known);
    logic [INST_W-1:0] w;
    logic [3:0]        op;
    known = 1'b1;
    a     = m_pc;
    if (m_valid) begin
      w  = word_at(m_cur);
      op = w[31:28];
      if (op == OP_JR) begin
`ifdef FETCH_RAS_EN
        if (m_stack.size() > 0) begin
          a = m_stack.pop_back();
        end else begin
          m_unf = 1'b1;
          known = 1'b0;
          a     = '0;
        end
`else
        a = EXT_RA;
`endif
      end else if (op == OP_J || op == OP_CALL || (op == OP_B && w[27])) begin
        a = w[ADDR_W-1:0];
      end
`ifdef FETCH_RAS_EN
      if (op == OP_CALL) begin
        m_stack.push_back(m_cur + 1'b1);
        if (m_stack.size() > RAS_DEPTH) begin
          void'(m_stack.pop_front());
        end
      end
`endif
    end
  endtask

  task automatic fetch_cycles(input int n);
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] nxt;
    logic [SB_W-1:0]   e;
    bit                known;
    for (int k = 0; k < n; k++) begin
      model_advance(a, known);
      nxt = a + 1'b1;
      if (known) exp_q.push_back({a, word_at(a)});
      step();
      if (known) begin
        e = exp_q.pop_front();
        check("fetch", 64'({inst_pc, inst_out}), 64'(e));
        check("fetch_pc", 64'(pc), 64'(nxt));
      end
      check("fetch_valid", 64'(inst_valid), 64'(1));
      check("ras_count", 64'(ras_count), 64'(m_count()));
      m_cur   = a;
      m_pc    = nxt;
      m_valid = 1'b1;
    end
  endtask

  task automatic flush_to(input logic [ADDR_W-1:0] addr, input bit with_stall);
    logic [ADDR_W-1:0] nxt;
    logic [SB_W-1:0]   e;
    nxt        = addr + 1'b1;
    flush      = 1'b1;
    flush_addr = addr;
    stall      = with_stall;
    exp_q.push_back({addr, word_at(addr)});
    step();
    e = exp_q.pop_front();
    check("flush_fetch", 64'({inst_pc, inst_out}), 64'(e));
    check("flush_pc", 64'(pc), 64'(nxt));
    check("flush_ras_count", 64'(ras_count), 64'(m_count()));
    flush   = 1'b0;
    stall   = 1'b0;
    m_cur   = addr;
    m_pc    = nxt;
    m_valid = 1'b1;
  endtask

  task automatic stall_cycles(input int n);
    stall = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      check("stall_hold", 64'({inst_pc, inst_out}), 64'({m_cur, word_at(m_cur)}));
      check("stall_pc", 64'(pc), 64'(m_pc));
      check("stall_ras_count", 64'(ras_count), 64'(m_count()));
    end
    stall = 1'b0;
  endtask

  task automatic exec_enter();
    mode = EXEC;
    step();
    check("enter_pc", 64'(pc), 64'(0));
    check("enter_valid", 64'(inst_valid), 64'(0));
    m_pc    = '0;
    m_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pc"}, 64'(pc), 64'(0));
    check({tag, "_inst"}, 64'(inst_out), 64'(0));
    check({tag, "_inst_pc"}, 64'(inst_pc), 64'(0));
    check({tag, "_valid"}, 64'(inst_valid), 64'(0));
    check({tag, "_ras_count"}, 64'(ras_count), 64'(0));
    check({tag, "_underflow"}, 64'(ras_underflow), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [ADDR_W-1:0] exp_pc;
    logic [ADDR_W-1:0] r_addr;

    for (int i = 0; i < PROG_N; i++) prog[i] = 32'h00A0_0000 | 32'(i);
    prog[0]   = 32'h11;
    prog[1]   = 32'h22;
    prog[2]   = 32'h33;
    prog[3]   = mk(OP_B, 1'b1, 12'd40);
    prog[5]   = mk(OP_CALL, 1'b0, 12'd20);
    prog[22]  = mk(OP_JR, 1'b0, 12'd0);
    prog[7]   = mk(OP_J, 1'b0, 12'd60);
    prog[127] = mk(OP_J, 1'b0, 12'd6);
    for (int i = 0; i < 9; i++) begin
      prog[60 + 2 * i] = mk(OP_CALL, 1'b0, 12'(62 + 2 * i));
      prog[61 + 2 * i] = mk(OP_JR, 1'b0, 12'd0);
    end
    prog[78] = mk(OP_JR, 1'b0, 12'd0);

    reset           = 1'b1;
    mode            = LOAD;
    we              = 1'b0;
    inst_in         = '0;
    stall           = 1'b0;
    flush           = 1'b0;
    flush_addr      = '0;
    ext_return_addr = EXT_RA;
    m_pc            = '0;
    m_cur           = '0;
    m_valid         = 1'b0;
    m_unf           = 1'b0;

    step();
    step();
    check_zero("reset");
    reset = 1'b0;

    // Program load, with we gaps on the first words
    exp_pc = '0;
    for (int i = 0; i < PROG_N; i++) begin
      if (i < 3) begin
        we = 1'b0;
        step();
        check("load_gap_pc", 64'(pc), 64'(exp_pc));
      end
      we      = 1'b1;
      inst_in = prog[i];
      step();
      exp_pc = exp_pc + 1'b1;
      check("load_pc", 64'(pc), 64'(exp_pc));
      if (i < 3) check("load_valid", 64'(inst_valid), 64'(0));
    end
    we = 1'b0;

    // Sequential fetch from 0; predicted branch at 3 then flush under stall
    exec_enter();
    fetch_cycles(4);
    flush_to(12'd4, 1'b1);

    // Call at 5 into 20, jr at 22 held by a three-cycle stall
    fetch_cycles(4);
    stall_cycles(3);
`ifdef FETCH_RAS_EN
    // Return to 6, then nine nested calls and nine returns
    fetch_cycles(21);
`else
    // jr follows the external return address, 0x7F jumps back to 6
    fetch_cycles(3);
`endif
    check("ras_underflow", 64'(ras_underflow), 64'(m_unf));

    // Random flush targets inside the straight-line region
    flush_to(12'd100, 1'b0);
    fetch_cycles(2);
    for (int r = 0; r < 4; r++) begin
      r_addr = 12'($urandom_range(100, 120));
      flush_to(r_addr, 1'($urandom_range(0, 1)));
      fetch_cycles(2);
    end

    // Asynchronous reset mid-EXEC, checked before any clock edge
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    m_stack.delete();
    m_unf = 1'b0;
    step();
    reset = 1'b0;
    exec_enter();
    fetch_cycles(3);

    if (exp_q.size() != 0) check("sb_empty", 64'(exp_q.size()), 64'(0));
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    if (!done) begin
      failures++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

endmodule
